// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NCH independent run-time-programmable clock dividers.
// Each channel divides clock_in by its own divisor and emits a registered
// square wave (clock_out) and a one-cycle period-start strobe (tick).
// Divisor writes go through a valid/ready port and are applied only at a
// period boundary (wrap), on sync_clear, or while the channel is disabled.
// Optional feature macro: CLKDIV_DUTY_EN adds cfg_hi (programmable high time).
module clock_divider_multi #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 32,
  parameter int DIV_RESET = 2,
  localparam int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             sync_clear,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [WIDTH-1:0] cfg_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [WIDTH-1:0] cfg_hi,
`endif
  output logic [NCH-1:0]   clock_out,
  output logic [NCH-1:0]   tick
);

  localparam logic [WIDTH-1:0] LP_DIV_RST = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] LP_HI_RST  = WIDTH'(DIV_RESET / 2);

  logic [NCH-1:0] w_pend;

  // Ready only looks at the addressed channel's pending flag; an
  // out-of-range channel always reads ready so the write is swallowed.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (cfg_ch == CHW'(i)) cfg_ready = !w_pend[i];
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] r_cnt, r_div, r_hi, r_pend_div;
    logic             r_pend, r_clk, r_tick;
`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0] r_pend_hi;
`endif
    logic [WIDTH-1:0] w_d;
    logic             w_wrap, w_restart, w_apply, w_accept;

    // div==0 behaves as divide-by-1
    assign w_d       = (r_div == '0) ? WIDTH'(1) : r_div;
    // >= rather than == so a counter can never run past its limit
    assign w_wrap    = (r_cnt >= (w_d - WIDTH'(1)));
    assign w_restart = sync_clear | ~en[g] | w_wrap;
    assign w_apply   = r_pend & w_restart;
    assign w_accept  = cfg_valid & ~r_pend & (cfg_ch == CHW'(g));

    assign w_pend[g]    = r_pend;
    assign clock_out[g] = r_clk;
    assign tick[g]      = r_tick;

    // Counter, outputs and glitch-free divisor update for this channel
    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        r_cnt      <= '0;
        r_div      <= LP_DIV_RST;
        r_hi       <= LP_HI_RST;
        r_pend     <= 1'b0;
        r_pend_div <= '0;
`ifdef CLKDIV_DUTY_EN
        r_pend_hi  <= '0;
`endif
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        // outputs are a registered view of the current count
        r_clk  <= en[g] & (r_cnt < r_hi);
        r_tick <= en[g] & (r_cnt == '0);

        if (w_restart) r_cnt <= '0;
        else           r_cnt <= r_cnt + WIDTH'(1);

        // apply and accept are exclusive: accept needs !pend, apply needs pend
        if (w_apply) begin
          r_div  <= r_pend_div;
`ifdef CLKDIV_DUTY_EN
          r_hi   <= r_pend_hi;
`else
          r_hi   <= r_pend_div >> 1;
`endif
          r_pend <= 1'b0;
        end else if (w_accept) begin
          r_pend     <= 1'b1;
          r_pend_div <= cfg_div;
`ifdef CLKDIV_DUTY_EN
          r_pend_hi  <= cfg_hi;
`endif
        end
      end
    end
  end

endmodule
